// File: rtl/cosim_mmio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cosim_mmio_arbiter
//  Purpose  : Shares one downstream MMIO command/response port between the
//             cosim read-request and write-request streams. It grants the two
//             streams round-robin and bounds the number of issued-but-unanswered
//             transactions. Each in-order response goes back to the stream that
//             issued the command.
//  Ports    : clk/rst                 - clock, async active-high reset
//             rd_req_* / wr_req_*     - request streams from the DPI shim
//             cmd_*                   - registered downstream command slot
//             rsp_*                   - in-order downstream responses
//             rd_rsp_* / wr_rsp_*     - response streams to the DPI shim
//             outstanding, orphan_err - status
//  Revision : 1.0 - initial release
// ============================================================================
module cosim_mmio_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_req_valid,
    output logic                               rd_req_ready,
    input  logic [ADDR_W-1:0]                  rd_req_addr,
    input  logic                               wr_req_valid,
    output logic                               wr_req_ready,
    input  logic [ADDR_W-1:0]                  wr_req_addr,
    input  logic [DATA_W-1:0]                  wr_req_data,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic                               cmd_write,
    output logic [ADDR_W-1:0]                  cmd_addr,
    output logic [DATA_W-1:0]                  cmd_wdata,
    input  logic                               rsp_valid,
    output logic                               rsp_ready,
    input  logic [DATA_W-1:0]                  rsp_data,
    input  logic                               rsp_error,
    output logic                               rd_rsp_valid,
    input  logic                               rd_rsp_ready,
    output logic [DATA_W-1:0]                  rd_rsp_data,
    output logic [7:0]                         rd_rsp_error,
    output logic                               wr_rsp_valid,
    input  logic                               wr_rsp_ready,
    output logic [7:0]                         wr_rsp_error,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                               orphan_err
);

    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);

    // Tag FIFO: one bit per transaction in flight (1 = write). The FIFO
    // occupancy always equals the outstanding count, so no separate counter.
    logic [MAX_OUTSTANDING-1:0] r_tag_mem;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]         r_outstanding;
    logic                       r_last_grant;   // 1 = last grant was a write
    logic                       r_orphan_err;

    logic w_slot_free;
    logic w_grant_ok;
    logic w_grant_rd;
    logic w_grant_wr;
    logic w_grant;
    logic w_fifo_empty;
    logic w_head_is_write;
    logic w_rsp_pop;

    // The slot counts as free in the same cycle its occupant is accepted,
    // so requests can follow each other back to back.
    assign w_slot_free = !cmd_valid || cmd_ready;
    assign w_grant_ok  = w_slot_free && (r_outstanding < c_MAX_CNT);

    // On a tie, grant the type that did not win last time.
    assign w_grant_rd = w_grant_ok && rd_req_valid && (!wr_req_valid || r_last_grant);
    assign w_grant_wr = w_grant_ok && wr_req_valid && (!rd_req_valid || !r_last_grant);
    assign w_grant    = w_grant_rd || w_grant_wr;

    assign rd_req_ready = w_grant_rd;
    assign wr_req_ready = w_grant_wr;

    assign w_fifo_empty    = (r_outstanding == '0);
    assign w_head_is_write = r_tag_mem[r_rd_ptr];

    always_comb begin
        rd_rsp_valid = 1'b0;
        wr_rsp_valid = 1'b0;
        rsp_ready    = 1'b1;        // with nothing in flight, drop orphans
        if (!w_fifo_empty) begin
            if (w_head_is_write) begin
                wr_rsp_valid = rsp_valid;
                rsp_ready    = wr_rsp_ready;
            end else begin
                rd_rsp_valid = rsp_valid;
                rsp_ready    = rd_rsp_ready;
            end
        end
    end

    assign w_rsp_pop    = rsp_valid && rsp_ready && !w_fifo_empty;
    assign rd_rsp_data  = rsp_data;
    assign rd_rsp_error = {7'b0, rsp_error};
    assign wr_rsp_error = {7'b0, rsp_error};
    assign outstanding  = r_outstanding;
    assign orphan_err   = r_orphan_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid     <= 1'b0;
            cmd_write     <= 1'b0;
            cmd_addr      <= '0;
            cmd_wdata     <= '0;
            r_tag_mem     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
            r_last_grant  <= 1'b1;
            r_orphan_err  <= 1'b0;
        end else begin
            // Command slot: load on grant, hold while stalled.
            if (w_grant) begin
                cmd_valid    <= 1'b1;
                cmd_write    <= w_grant_wr;
                cmd_addr     <= w_grant_wr ? wr_req_addr : rd_req_addr;
                cmd_wdata    <= w_grant_wr ? wr_req_data : '0;
                r_last_grant <= w_grant_wr;
                r_tag_mem[r_wr_ptr] <= w_grant_wr;
                r_wr_ptr     <= r_wr_ptr + c_PTR_W'(1);
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            if (w_rsp_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            // The count covers the staged slot as well, so the FIFO cannot
            // overflow.
            case ({w_grant, w_rsp_pop})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (rsp_valid && w_fifo_empty) begin
                r_orphan_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cosim_mmio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cosim_mmio_arbiter
//  Purpose  : Directed self-checking bench for cosim_mmio_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cosim_mmio_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int MAX_OUTSTANDING = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req_valid, rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              wr_req_valid, wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_error;
    logic [DATA_W-1:0] rsp_data;
    logic              rd_rsp_valid, rd_rsp_ready;
    logic [DATA_W-1:0] rd_rsp_data;
    logic [7:0]        rd_rsp_error;
    logic              wr_rsp_valid, wr_rsp_ready;
    logic [7:0]        wr_rsp_error;
    logic [2:0]        outstanding;
    logic              orphan_err;

    int n_checks = 0;
    int n_errors = 0;

    cosim_mmio_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
        .rd_rsp_error(rd_rsp_error),
        .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready), .wr_rsp_error(wr_rsp_error),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_cmd_write"}, 64'(cmd_write), 64'd0);
        check({tag, "_cmd_addr"},  64'(cmd_addr), 64'd0);
        check({tag, "_cmd_wdata"}, cmd_wdata, 64'd0);
        check({tag, "_outstanding"}, 64'(outstanding), 64'd0);
        check({tag, "_orphan"}, 64'(orphan_err), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        rd_req_valid = 0; rd_req_addr = '0;
        wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0;
        cmd_ready = 0;
        rsp_valid = 0; rsp_data = '0; rsp_error = 0;
        rd_rsp_ready = 0; wr_rsp_ready = 0;
        tick(); tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        // ---- single read ----
        cmd_ready = 1;
        rd_req_valid = 1; rd_req_addr = 32'h40;
        #1;
        check("rd1_req_ready", 64'(rd_req_ready), 64'd1);
        check("rd1_wr_req_ready", 64'(wr_req_ready), 64'd0);
        tick();
        rd_req_valid = 0;
        check("rd1_cmd_valid", 64'(cmd_valid), 64'd1);
        check("rd1_cmd_write", 64'(cmd_write), 64'd0);
        check("rd1_cmd_addr", 64'(cmd_addr), 64'h40);
        check("rd1_cmd_wdata", cmd_wdata, 64'd0);
        check("rd1_out1", 64'(outstanding), 64'd1);
        rsp_valid = 1; rsp_data = 64'hDEADBEEF_00000001; rsp_error = 0; rd_rsp_ready = 1;
        #1;
        check("rd1_rsp_valid", 64'(rd_rsp_valid), 64'd1);
        check("rd1_rsp_data", rd_rsp_data, 64'hDEADBEEF_00000001);
        check("rd1_rsp_error", 64'(rd_rsp_error), 64'h00);
        check("rd1_wr_rsp_valid", 64'(wr_rsp_valid), 64'd0);
        check("rd1_rsp_ready", 64'(rsp_ready), 64'd1);
        tick();
        rsp_valid = 0;
        check("rd1_out0", 64'(outstanding), 64'd0);
        check("rd1_cmd_done", 64'(cmd_valid), 64'd0);

        // ---- single write ----
        wr_req_valid = 1; wr_req_addr = 32'h10; wr_req_data = 64'h55;
        #1;
        check("wr1_req_ready", 64'(wr_req_ready), 64'd1);
        tick();
        wr_req_valid = 0;
        check("wr1_cmd_valid", 64'(cmd_valid), 64'd1);
        check("wr1_cmd_write", 64'(cmd_write), 64'd1);
        check("wr1_cmd_addr", 64'(cmd_addr), 64'h10);
        check("wr1_cmd_wdata", cmd_wdata, 64'h55);
        rsp_valid = 1; rsp_error = 1; wr_rsp_ready = 1; rd_rsp_ready = 0;
        #1;
        check("wr1_rsp_valid", 64'(wr_rsp_valid), 64'd1);
        check("wr1_rsp_error", 64'(wr_rsp_error), 64'h01);
        check("wr1_rd_rsp_valid", 64'(rd_rsp_valid), 64'd0);
        tick();
        rsp_valid = 0; rsp_error = 0; wr_rsp_ready = 0;
        check("wr1_out0", 64'(outstanding), 64'd0);

        // ---- both streams valid: R,W,R,W then stall at 4 ----
        rd_req_valid = 1; rd_req_addr = 32'h100;
        wr_req_valid = 1; wr_req_addr = 32'h200; wr_req_data = 64'hAB;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr%0d_rd_ready", i), 64'(rd_req_ready), 64'((i % 2) == 0));
            check($sformatf("rr%0d_wr_ready", i), 64'(wr_req_ready), 64'((i % 2) == 1));
            tick();
            check($sformatf("rr%0d_cmd_write", i), 64'(cmd_write), 64'((i % 2) == 1));
            check($sformatf("rr%0d_cmd_addr", i), 64'(cmd_addr), (i % 2) ? 64'h200 : 64'h100);
            check($sformatf("rr%0d_out", i), 64'(outstanding), 64'(i + 1));
        end
        #1;
        check("full_rd_ready", 64'(rd_req_ready), 64'd0);
        check("full_wr_ready", 64'(wr_req_ready), 64'd0);
        tick();
        check("full_out", 64'(outstanding), 64'd4);
        rd_req_valid = 0; wr_req_valid = 0;

        // ---- responses: R held by shim, then W with a simultaneous grant ----
        rsp_valid = 1; rsp_data = 64'h1111; rd_rsp_ready = 0; wr_rsp_ready = 1;
        #1;
        check("r0_rd_rsp_valid", 64'(rd_rsp_valid), 64'd1);
        check("r0_wr_rsp_valid", 64'(wr_rsp_valid), 64'd0);
        check("r0_rsp_ready_hold", 64'(rsp_ready), 64'd0);
        tick();
        check("r0_out_hold", 64'(outstanding), 64'd4);
        check("r0_rd_rsp_still", 64'(rd_rsp_valid), 64'd1);
        rd_rsp_ready = 1;
        #1;
        check("r0_rsp_ready", 64'(rsp_ready), 64'd1);
        tick();
        check("r0_out", 64'(outstanding), 64'd3);
        rd_req_valid = 1; rd_req_addr = 32'h300;
        #1;
        check("r1_wr_rsp_valid", 64'(wr_rsp_valid), 64'd1);
        check("r1_rd_rsp_valid", 64'(rd_rsp_valid), 64'd0);
        check("r1_grant", 64'(rd_req_ready), 64'd1);
        tick();
        rd_req_valid = 0;
        check("r1_out_same", 64'(outstanding), 64'd3);
        check("r1_cmd_addr", 64'(cmd_addr), 64'h300);
        // Remaining FIFO: R, W, R(0x300)
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("r%0d_rd_rsp_valid", i + 2), 64'(rd_rsp_valid), 64'((i % 2) == 0));
            check($sformatf("r%0d_wr_rsp_valid", i + 2), 64'(wr_rsp_valid), 64'((i % 2) == 1));
            tick();
            check($sformatf("r%0d_out", i + 2), 64'(outstanding), 64'(2 - i));
        end
        rsp_valid = 0; rd_rsp_ready = 0; wr_rsp_ready = 0;

        // ---- downstream stall ----
        cmd_ready = 0;
        rd_req_valid = 1; rd_req_addr = 32'h500;
        tick();
        check("st_cmd_valid", 64'(cmd_valid), 64'd1);
        wr_req_valid = 1; wr_req_addr = 32'h600; wr_req_data = 64'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("st%0d_addr", i), 64'(cmd_addr), 64'h500);
            check($sformatf("st%0d_wdata", i), cmd_wdata, 64'd0);
            check($sformatf("st%0d_rd_ready", i), 64'(rd_req_ready), 64'd0);
            check($sformatf("st%0d_wr_ready", i), 64'(wr_req_ready), 64'd0);
            tick();
        end
        cmd_ready = 1;
        #1;
        check("st_rel_wr_ready", 64'(wr_req_ready), 64'd1);
        check("st_rel_rd_ready", 64'(rd_req_ready), 64'd0);
        tick();
        rd_req_valid = 0; wr_req_valid = 0;
        check("st_rel_cmd_write", 64'(cmd_write), 64'd1);
        check("st_rel_cmd_addr", 64'(cmd_addr), 64'h600);
        check("st_rel_cmd_wdata", cmd_wdata, 64'h77);
        check("st_out2", 64'(outstanding), 64'd2);

        // ---- async reset with two outstanding ----
        rst = 1;
        #1;
        check_reset_state("mid_rst");
        tick();
        rst = 0;
        tick();

        // ---- late / orphan response ----
        rsp_valid = 1; rsp_data = 64'h99;
        #1;
        check("orph_rsp_ready", 64'(rsp_ready), 64'd1);
        check("orph_rd_rsp_valid", 64'(rd_rsp_valid), 64'd0);
        check("orph_wr_rsp_valid", 64'(wr_rsp_valid), 64'd0);
        tick();
        rsp_valid = 0;
        check("orph_flag", 64'(orphan_err), 64'd1);
        check("orph_out", 64'(outstanding), 64'd0);
        tick(); tick();
        check("orph_sticky", 64'(orphan_err), 64'd1);
        rst = 1;
        #1;
        check("orph_cleared", 64'(orphan_err), 64'd0);
        tick();
        rst = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
